// File: rtl/mem_access_unit.sv
// Multi-cycle load/store sequencer between the register file and a handshaked data memory.
// Holds fetch via Stall while an access is outstanding and flags memory timeouts on Fault.
module mem_access_unit #(
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic         IsStore,
    input  logic [W-1:0] Addr,
    input  logic [W-1:0] StoreData,
    output logic         MemReq,
    output logic         MemWe,
    output logic [W-1:0] MemAddr,
    output logic [W-1:0] MemWData,
    input  logic         MemAck,
    input  logic [W-1:0] MemRData,
    output logic         Stall,
    output logic         WbEn,
    output logic [W-1:0] WbData,
    output logic         Fault
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [W-1:0]  addr_q, addr_d;
    logic [W-1:0]  wdata_q, wdata_d;
    logic          wb_en_q, wb_en_d;
    logic [W-1:0]  wb_data_q, wb_data_d;
    logic          fault_q, fault_d;

    // Next-state and next-output logic; DONE accepts a new Start exactly like IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wb_en_d   = 1'b0;
        wb_data_d = wb_data_q;
        fault_d   = fault_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    addr_d  = Addr;
                    wdata_d = StoreData;
                    we_d    = IsStore;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (MemAck) begin
                    if (!we_q) begin
                        wb_data_d = MemRData;
                        wb_en_d   = 1'b1;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_d = (state_d == S_BUSY);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wb_en_q   <= 1'b0;
            wb_data_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wb_en_q   <= wb_en_d;
            wb_data_q <= wb_data_d;
            fault_q   <= fault_d;
        end
    end

    assign MemReq   = req_q;
    assign MemWe    = we_q;
    assign MemAddr  = addr_q;
    assign MemWData = wdata_q;
    assign WbEn     = wb_en_q;
    assign WbData   = wb_data_q;
    assign Fault    = fault_q;

    // Fetch is released in DONE so the PC advances while the writeback lands.
    assign Stall = (state_q == S_BUSY) | (Start & (state_q == S_IDLE));

endmodule
